// File: rtl/core_ex_commit_pkg.sv
// rtl/core_ex_commit_pkg.sv - shared types and constants for the commit/trap controller
package core_ex_commit_pkg;

    localparam int CORE_XLEN = 32;

    typedef enum logic [1:0] {
        CMT_ST_IDLE  = 2'd0,
        CMT_ST_TRAP  = 2'd1,
        CMT_ST_MRET  = 2'd2,
        CMT_ST_FLUSH = 2'd3
    } cmt_state_e;

    // Low bits of mcause; the interrupt flag sits in the top bit
    localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR  = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
    localparam logic [3:0] CAUSE_LD_MISALIGN    = 4'd4;
    localparam logic [3:0] CAUSE_ST_MISALIGN    = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;
    localparam logic [3:0] CAUSE_M_EXT_IRQ      = 4'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/core_trap_cause_enc.sv
// rtl/core_trap_cause_enc.sv - priority encoder from retire flags to trap/mret/cause
module core_trap_cause_enc
    import core_ex_commit_pkg::*;
#(
    parameter int XLEN = CORE_XLEN
) (
    input  logic            irq,
    input  logic            ifu_misalgn,
    input  logic            ilegl,
    input  logic            ebreak,
    input  logic            ecall,
    input  logic            ld_misalgn,
    input  logic            st_misalgn,
    input  logic            mret_flag,
    output logic            trap,
    output logic            mret,
    output logic [XLEN-1:0] cause
);

    always_comb begin
        trap  = 1'b1;
        mret  = 1'b0;
        cause = '0;
        if (irq) begin
            cause           = XLEN'(CAUSE_M_EXT_IRQ);
            cause[XLEN-1]   = 1'b1;
        end else if (ifu_misalgn) begin
            cause = XLEN'(CAUSE_INSTR_MISALIGN);
        end else if (ilegl) begin
            cause = XLEN'(CAUSE_ILLEGAL_INSTR);
        end else if (ebreak) begin
            cause = XLEN'(CAUSE_BREAKPOINT);
        end else if (ecall) begin
            cause = XLEN'(CAUSE_ECALL_M);
        end else if (ld_misalgn) begin
            cause = XLEN'(CAUSE_LD_MISALIGN);
        end else if (st_misalgn) begin
            cause = XLEN'(CAUSE_ST_MISALIGN);
        end else begin
            trap = 1'b0;
            mret = mret_flag;
        end
    end

endmodule

// File: rtl/core_ex_commit.sv
// rtl/core_ex_commit.sv - commit/trap controller sequencing CSR writes and fetch redirect
module core_ex_commit
    import core_ex_commit_pkg::*;
#(
    parameter int XLEN = CORE_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmt_valid,
    output logic            cmt_ready,
    input  logic [XLEN-1:0] cmt_pc,
    input  logic            cmt_ifu_misalgn,
    input  logic            cmt_ilegl,
    input  logic            cmt_ecall,
    input  logic            cmt_ebreak,
    input  logic            cmt_ld_misalgn,
    input  logic            cmt_st_misalgn,
    input  logic            cmt_mret,
    input  logic            ext_irq,
    output logic            cmt_wb_en,
    input  logic [XLEN-1:0] csr_mstatus_r,
    input  logic [XLEN-1:0] csr_mtvec_r,
    input  logic [XLEN-1:0] csr_mepc_r,
    output logic            cmt_mstatus_en,
    output logic            cmt_mcause_en,
    output logic            cmt_mepc_en,
    output logic [XLEN-1:0] cmt_mstatus,
    output logic [XLEN-1:0] cmt_mcause,
    output logic [XLEN-1:0] cmt_mepc,
    output logic            flush_req,
    output logic [XLEN-1:0] flush_pc,
    input  logic            flush_ack
);

    cmt_state_e      state_q, state_d;
    logic [XLEN-1:0] cause_q, pc_q, target_q;
    logic            transfer, enc_trap, enc_mret;
    logic [XLEN-1:0] enc_cause, trap_target;

    assign transfer = cmt_valid & cmt_ready;

    core_trap_cause_enc #(.XLEN(XLEN)) u_cause_enc (
        .irq         (ext_irq & csr_mstatus_r[MSTATUS_MIE]),
        .ifu_misalgn (cmt_ifu_misalgn),
        .ilegl       (cmt_ilegl),
        .ebreak      (cmt_ebreak),
        .ecall       (cmt_ecall),
        .ld_misalgn  (cmt_ld_misalgn),
        .st_misalgn  (cmt_st_misalgn),
        .mret_flag   (cmt_mret),
        .trap        (enc_trap),
        .mret        (enc_mret),
        .cause       (enc_cause)
    );

    // Vectored mode only redirects interrupts; exceptions always use the base
    always_comb begin
        trap_target = {csr_mtvec_r[XLEN-1:2], 2'b00};
        if (csr_mtvec_r[1:0] == 2'b01 && cause_q[XLEN-1])
            trap_target = trap_target + XLEN'(4 * 11);
    end

    always_comb begin
        state_d        = state_q;
        cmt_ready      = 1'b0;
        cmt_wb_en      = 1'b0;
        cmt_mstatus_en = 1'b0;
        cmt_mcause_en  = 1'b0;
        cmt_mepc_en    = 1'b0;
        cmt_mstatus    = '0;
        cmt_mcause     = '0;
        cmt_mepc       = '0;
        flush_req      = 1'b0;
        flush_pc       = '0;
        case (state_q)
            CMT_ST_IDLE: begin
                cmt_ready = 1'b1;
                cmt_wb_en = transfer & ~(enc_trap | enc_mret);
                if (transfer && enc_trap)
                    state_d = CMT_ST_TRAP;
                else if (transfer && enc_mret)
                    state_d = CMT_ST_MRET;
            end
            CMT_ST_TRAP: begin
                cmt_mstatus_en = 1'b1;
                cmt_mcause_en  = 1'b1;
                cmt_mepc_en    = 1'b1;
                cmt_mcause     = cause_q;
                cmt_mepc       = {pc_q[XLEN-1:1], 1'b0};
                cmt_mstatus    = csr_mstatus_r;
                cmt_mstatus[MSTATUS_MPIE]                  = csr_mstatus_r[MSTATUS_MIE];
                cmt_mstatus[MSTATUS_MIE]                   = 1'b0;
                cmt_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                state_d = CMT_ST_FLUSH;
            end
            CMT_ST_MRET: begin
                cmt_mstatus_en = 1'b1;
                cmt_mstatus    = csr_mstatus_r;
                cmt_mstatus[MSTATUS_MIE]                   = csr_mstatus_r[MSTATUS_MPIE];
                cmt_mstatus[MSTATUS_MPIE]                  = 1'b1;
                cmt_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                state_d = CMT_ST_FLUSH;
            end
            CMT_ST_FLUSH: begin
                flush_req = 1'b1;
                flush_pc  = target_q;
                if (flush_ack)
                    state_d = CMT_ST_IDLE;
            end
            default: state_d = CMT_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CMT_ST_IDLE;
            cause_q  <= '0;
            pc_q     <= '0;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            if (transfer && enc_trap) begin
                cause_q <= enc_cause;
                pc_q    <= cmt_pc;
            end
            if (state_q == CMT_ST_TRAP)
                target_q <= trap_target;
            else if (state_q == CMT_ST_MRET)
                target_q <= csr_mepc_r;
        end
    end

endmodule

// File: tb/tb_core_ex_commit.sv
// tb/tb_core_ex_commit.sv - directed and randomized bench for core_ex_commit against a reference model
module tb_core_ex_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmt_valid, cmt_ready, ext_irq, cmt_wb_en, flush_ack, flush_req;
    logic [31:0] cmt_pc, csr_mstatus_r, csr_mtvec_r, csr_mepc_r;
    logic [6:0]  flags;
    logic        cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en;
    logic [31:0] cmt_mstatus, cmt_mcause, cmt_mepc, flush_pc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    core_ex_commit dut (
        .clk             (clk),
        .rst             (rst),
        .cmt_valid       (cmt_valid),
        .cmt_ready       (cmt_ready),
        .cmt_pc          (cmt_pc),
        .cmt_ifu_misalgn (flags[0]),
        .cmt_ilegl       (flags[1]),
        .cmt_ecall       (flags[2]),
        .cmt_ebreak      (flags[3]),
        .cmt_ld_misalgn  (flags[4]),
        .cmt_st_misalgn  (flags[5]),
        .cmt_mret        (flags[6]),
        .ext_irq         (ext_irq),
        .cmt_wb_en       (cmt_wb_en),
        .csr_mstatus_r   (csr_mstatus_r),
        .csr_mtvec_r     (csr_mtvec_r),
        .csr_mepc_r      (csr_mepc_r),
        .cmt_mstatus_en  (cmt_mstatus_en),
        .cmt_mcause_en   (cmt_mcause_en),
        .cmt_mepc_en     (cmt_mepc_en),
        .cmt_mstatus     (cmt_mstatus),
        .cmt_mcause      (cmt_mcause),
        .cmt_mepc        (cmt_mepc),
        .flush_req       (flush_req),
        .flush_pc        (flush_pc),
        .flush_ack       (flush_ack)
    );

    typedef struct {
        int          kind;      // 0 retire, 1 trap, 2 mret
        logic [31:0] cause;
        logic [31:0] mstatus;
        logic [31:0] mepc;
        logic [31:0] target;
    } exp_t;

    function automatic exp_t model(input logic [31:0] pc, input logic [6:0] fl, input logic irq,
                                   input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep);
        int   prio_bit[6]   = '{1, 2, 4, 3, 5, 6};
        int   prio_cause[6] = '{0, 2, 3, 11, 4, 6};
        exp_t e;
        e.kind = 0; e.cause = 0; e.mstatus = ms; e.mepc = pc & ~32'h1; e.target = 0;
        if (irq && ms[3]) begin
            e.kind  = 1;
            e.cause = 32'h8000_000B;
        end else begin
            for (int k = 5; k >= 0; k--)
                if (fl[prio_bit[k] - 1]) begin
                    e.kind  = 1;
                    e.cause = prio_cause[k];
                end
            if (e.kind == 0 && fl[6]) e.kind = 2;
        end
        if (e.kind == 1) begin
            e.mstatus[7]     = ms[3];
            e.mstatus[3]     = 1'b0;
            e.mstatus[12:11] = 2'b11;
            e.target = tv & ~32'h3;
            if (tv[1:0] == 2'b01 && e.cause[31]) e.target = e.target + 44;
        end else if (e.kind == 2) begin
            e.mstatus[3]     = ms[7];
            e.mstatus[7]     = 1'b1;
            e.mstatus[12:11] = 2'b11;
            e.target = ep;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic ready);
        chk({tag, "/ready"}, 32'(cmt_ready), 32'(ready));
        chk({tag, "/strobes"}, 32'({cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en}), 32'd0);
        chk({tag, "/flush_req"}, 32'(flush_req), 32'd0);
    endtask

    task automatic run_txn(input string tag, input logic [31:0] pc, input logic [6:0] fl, input logic irq,
                           input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep, input int n);
        exp_t e;
        e = model(pc, fl, irq, ms, tv, ep);
        @(posedge clk); #1;
        cmt_valid = 1'b1; cmt_pc = pc; flags = fl; ext_irq = irq;
        csr_mstatus_r = ms; csr_mtvec_r = tv; csr_mepc_r = ep;
        flush_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk_quiet({tag, "/accept"}, 1'b1);
        chk({tag, "/wb_en"}, 32'(cmt_wb_en), 32'(e.kind == 0));
        @(posedge clk); #1;
        flags = '0;
        ext_irq = 1'($urandom_range(0, 1));
        cmt_valid = (e.kind == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        flush_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (e.kind == 0) begin
            chk_quiet({tag, "/after_retire"}, 1'b1);
            ext_irq = 1'b0;
            flush_ack = 1'b0;
            return;
        end
        chk({tag, "/csr_ready"}, 32'(cmt_ready), 32'd0);
        chk({tag, "/csr_wb_en"}, 32'(cmt_wb_en), 32'd0);
        chk({tag, "/csr_flush_req"}, 32'(flush_req), 32'd0);
        chk({tag, "/strobes"}, 32'({cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en}),
            (e.kind == 1) ? 32'd7 : 32'd4);
        chk({tag, "/mstatus"}, cmt_mstatus, e.mstatus);
        if (e.kind == 1) begin
            chk({tag, "/mcause"}, cmt_mcause, e.cause);
            chk({tag, "/mepc"}, cmt_mepc, e.mepc);
        end
        for (int i = 0; i <= n; i++) begin
            @(posedge clk); #1;
            flush_ack = (i == n);
            @(negedge clk);
            chk({tag, "/flush_req"}, 32'(flush_req), 32'd1);
            chk({tag, "/flush_pc"}, flush_pc, e.target);
            chk({tag, "/flush_ready"}, 32'(cmt_ready), 32'd0);
            chk({tag, "/flush_strobes"}, 32'({cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en, cmt_wb_en}), 32'd0);
        end
        @(posedge clk); #1;
        flush_ack = 1'b0; cmt_valid = 1'b0; ext_irq = 1'b0;
        @(negedge clk);
        chk_quiet({tag, "/back_idle"}, 1'b1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk_quiet(tag, 1'b1);
        chk({tag, "/wb_en"}, 32'(cmt_wb_en), 32'd0);
        chk({tag, "/mstatus"}, cmt_mstatus, 32'd0);
        chk({tag, "/mcause"}, cmt_mcause, 32'd0);
        chk({tag, "/mepc"}, cmt_mepc, 32'd0);
        chk({tag, "/flush_pc"}, flush_pc, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cmt_valid = 1'b0; cmt_pc = '0; flags = '0; ext_irq = 1'b0; flush_ack = 1'b0;
        csr_mstatus_r = '0; csr_mtvec_r = '0; csr_mepc_r = '0;
        repeat (2) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;

        run_txn("retire",     32'h8000_0010, 7'b0000000, 1'b0, 32'h0,    32'h0,         32'h0,         0);
        run_txn("ecall",      32'h8000_0100, 7'b0000100, 1'b0, 32'h8,    32'h8000_0200, 32'h0,         0);
        run_txn("mret",       32'h8000_0200, 7'b1000000, 1'b0, 32'h1880, 32'h8000_0200, 32'h8000_0104, 0);
        run_txn("irq_vec",    32'h8000_0300, 7'b0000010, 1'b1, 32'h8,    32'h8000_0201, 32'h0,         1);
        run_txn("ilegl_ld",   32'h8000_0401, 7'b0010010, 1'b0, 32'h8,    32'h8000_0201, 32'h0,         0);
        run_txn("irq_masked", 32'h8000_0500, 7'b0000000, 1'b1, 32'h80,   32'h8000_0201, 32'h0,         0);
        run_txn("ack_delay5", 32'h8000_0600, 7'b0100000, 1'b0, 32'h8,    32'h8000_0300, 32'h0,         5);

        // Reset pulse while the controller sits in TRAP
        @(posedge clk); #1;
        cmt_valid = 1'b1; cmt_pc = 32'h8000_0700; flags = 7'b0001000; csr_mstatus_r = 32'h8;
        @(posedge clk); #1;
        cmt_valid = 1'b0; flags = '0;
        #1 rst = 1'b1;
        #1 chk_reset_values("rst_in_trap");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_values("after_rst");
        run_txn("post_rst", 32'h8000_0800, 7'b0000000, 1'b0, 32'h8, 32'h0, 32'h0, 0);

        for (int t = 0; t < 300; t++) begin
            logic [6:0] fl;
            for (int b = 0; b < 7; b++) fl[b] = ($urandom_range(0, 5) == 0);
            run_txn($sformatf("rand%0d", t), $urandom, fl, 1'($urandom_range(0, 3) == 0),
                    $urandom, $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
